systolic_job_ctrl: RTL

- Job controller and two-requester arbiter for the 3x3 weight-stationary systolic array (`sysa`).
- Grants the array to one requester per job, round-robin, and loads three 32-bit weight words and three 24-bit input vectors.
- Clears the array, then runs a fixed 7-cycle compute window and collects the 9 column outputs.
- Streams the 9 results back with valid/ready backpressure, tagged with the owning requester.

---
 rtl/systolic_job_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/systolic_job_ctrl.sv
// Job controller and two-requester round-robin arbiter for the 3x3
// weight-stationary systolic array. A granted requester streams three weight
// words and three input vectors; the controller clears the array, runs the
// fixed compute window while capturing the skewed column outputs, then
// drains the nine results with valid/ready backpressure.
module systolic_job_ctrl #(
    parameter int DW      = 8,
    parameter int ACC_W   = 16,
    parameter int N       = 3,
    parameter int RUN_CYC = 7
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [31:0]         req0_data,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [31:0]         req1_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ACC_W-1:0]    res_data,
    output logic                res_id,
    output logic                res_last,
    output logic                busy,
    output logic                sa_rst,
    output logic                sa_en,
    output logic [N*32-1:0]     sa_w,
    output logic [N*DW-1:0]     sa_in,
    input  logic [ACC_W-1:0]    sa_out1,
    input  logic [ACC_W-1:0]    sa_out2,
    input  logic [ACC_W-1:0]    sa_out3
);

    localparam int WW   = 32;
    localparam int XW   = N * DW;
    localparam int NRES = N * N;

    localparam logic [3:0] LAST_WORD = 4'(N - 1);
    localparam logic [3:0] LAST_R    = 4'(RUN_CYC - 1);
    localparam logic [3:0] LAST_K    = 4'(NRES - 1);
    localparam logic [3:0] NX        = 4'(N);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_X,
        CLEAR,
        RUN,
        DRAIN
    } state_t;

    state_t            state_q;
    logic              gnt_q;     // requester owning the current job
    logic              rr_q;      // preferred requester when both ask at once
    logic [3:0]        cnt_q;     // word index, run cycle r, or result index k

    logic [WW-1:0]     w_q   [N];
    logic [XW-1:0]     x_q   [N];
    logic [ACC_W-1:0]  res_q [NRES];
    logic [ACC_W-1:0]  col   [N];

    logic              loading;
    logic              cur_valid;
    logic [WW-1:0]     cur_data;
    logic              word_fire;

    assign col[0] = sa_out1;
    assign col[1] = sa_out2;
    assign col[2] = sa_out3;

    // Only the granted requester's channel is ever looked at.
    assign loading   = (state_q == LOAD_W) || (state_q == LOAD_X);
    assign cur_valid = gnt_q ? req1_valid : req0_valid;
    assign cur_data  = gnt_q ? req1_data  : req0_data;
    assign word_fire = loading && cur_valid;

    // Job sequencing: grant, load, clear, fixed run window, drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // The grant cycle itself does not consume a word.
                    if (req0_valid || req1_valid) begin
                        gnt_q   <= (req0_valid && req1_valid) ? rr_q : req1_valid;
                        state_q <= LOAD_W;
                        cnt_q   <= '0;
                    end
                end
                LOAD_W: begin
                    if (word_fire) begin
                        if (cnt_q == LAST_WORD) begin
                            state_q <= LOAD_X;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                LOAD_X: begin
                    if (word_fire) begin
                        if (cnt_q == LAST_WORD) begin
                            state_q <= CLEAR;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                CLEAR: begin
                    state_q <= RUN;
                    cnt_q   <= '0;
                end
                RUN: begin
                    if (cnt_q == LAST_R) begin
                        state_q <= DRAIN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DRAIN: begin
                    // Grant stays locked until the last result is taken.
                    if (res_ready) begin
                        if (cnt_q == LAST_K) begin
                            state_q <= IDLE;
                            rr_q    <= ~gnt_q;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Weight/input buffers and de-skewing result capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                w_q[i] <= '0;
                x_q[i] <= '0;
            end
            for (int i = 0; i < NRES; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            if (state_q == LOAD_W && word_fire) begin
                w_q[cnt_q[1:0]] <= cur_data;
            end
            if (state_q == LOAD_X && word_fire) begin
                x_q[cnt_q[1:0]] <= cur_data[XW-1:0];
            end
            if (state_q == RUN) begin
                // Column c is valid for r = c+1 .. c+N because of the array skew.
                for (int c = 0; c < N; c++) begin
                    if (cnt_q >= 4'(c + 1) && cnt_q <= 4'(c + N)) begin
                        res_q[4'(c * N) + cnt_q - 4'(c + 1)] <= col[c];
                    end
                end
            end
        end
    end

    // Array-side drive: weights held between jobs, inputs only in RUN.
    always_comb begin
        sa_w = '0;
        for (int k = 0; k < N; k++) begin
            sa_w[k*WW +: WW] = w_q[k];
        end
        sa_in = '0;
        if (state_q == RUN && cnt_q < NX) begin
            sa_in = x_q[cnt_q[1:0]];
        end
    end

    // Requester and result-side decode of the registered state.
    always_comb begin
        req0_ready = loading && !gnt_q;
        req1_ready = loading && gnt_q;
        busy       = (state_q != IDLE);
        sa_rst     = (state_q == CLEAR);
        sa_en      = (state_q == RUN);
        res_valid  = (state_q == DRAIN);
        res_data   = '0;
        res_id     = 1'b0;
        res_last   = 1'b0;
        if (state_q == DRAIN) begin
            res_data = res_q[cnt_q];
            res_id   = gnt_q;
            res_last = (cnt_q == LAST_K);
        end
    end

endmodule
